hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the forwarding unit and decides each cycle whether PC and IF/ID advance, hold or flush, and whether ID/EX is loaded with a bubble. It covers three cases: load-use hazards that forwarding cannot resolve, taken branches and jumps, and a multi-cycle multiply/divide unit that writes HI/LO. It also tracks busy state for the multiply/divide unit and keeps a saturating stall counter for performance measurement.

## Interface
Parameters:
- MUL_CYCLES, default 4: EX-occupancy cycles of a mult/multu.
- DIV_CYCLES, default 32: EX-occupancy cycles of a div/divu.
- CNT_W, default 6: width of the mul/div down-counter; must hold DIV_CYCLES-1.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- rs_id, input, 5: rs field of the instruction in ID.
- rt_id, input, 5: rt field of the instruction in ID.
- uses_rs_id, input, 1: ID instruction reads rs.
- uses_rt_id, input, 1: ID instruction reads rt.
- MemRead_EX, input, 1: EX instruction is a load.
- rw_EX, input, 5: destination register of the EX instruction.
- branch_taken_EX, input, 1: branch resolved taken in EX.
- jump_ID, input, 1: j/jal/jr decoded in ID.
- md_start_ID, input, 1: ID instruction is mult/multu/div/divu.
- md_is_div_ID, input, 1: with md_start_ID, selects DIV_CYCLES.
- md_read_ID, input, 1: ID instruction is mfhi/mflo/mthi/mtlo.
- pc_wr, output, 1: PC register load enable.
- ifid_wr, output, 1: IF/ID register load enable.
- ifid_flush, output, 1: IF/ID loads a NOP.
- idex_flush, output, 1: ID/EX loads a bubble (all control bits 0).
- md_busy, output, 1: mul/div unit occupied.
- md_done, output, 1: last busy cycle of the current mul/div operation; the HI/LO write strobe.
- stall_cnt, output, 16: saturating count of stall cycles.

## Operation
Hazard terms:
- load_use = MemRead_EX && rw_EX!=0 && ((uses_rs_id && rw_EX==rs_id) || (uses_rt_id && rw_EX==rt_id)).
- md_stall = md_busy && (md_start_ID || md_read_ID).
- stall = load_use || md_stall.

Output priority, highest first:
1. **rst**: pc_wr=0, ifid_wr=0, ifid_flush=1, idex_flush=1.
2. **branch_taken_EX**: pc_wr=1, ifid_wr=1, ifid_flush=1, idex_flush=1. Any stall is ignored, because the ID instruction is squashed.
3. **stall**: pc_wr=0, ifid_wr=0, ifid_flush=0, idex_flush=1. jump_ID is ignored and re-evaluated next cycle.
4. **jump_ID**: pc_wr=1, ifid_wr=1, ifid_flush=1, idex_flush=0.
5. **otherwise**: pc_wr=1, ifid_wr=1, ifid_flush=0, idex_flush=0.

Mul/div sequencer FSM:
- States are IDLE, MUL and DIV, with a down-counter cnt of width CNT_W.
- accept = md_start_ID && !stall && !branch_taken_EX && !rst.
- **IDLE**: on accept, go to DIV with cnt=DIV_CYCLES-1 if md_is_div_ID, else to MUL with cnt=MUL_CYCLES-1.
- **MUL/DIV**: if cnt!=0, decrement cnt. If cnt==0, return to IDLE.
- md_busy = (state!=IDLE).
- md_done = md_busy && cnt==0.
- accept cannot occur while busy, because md_stall blocks it.
- A branch that is taken while the unit is busy does not abort the operation. The operation belongs to an older instruction.

Stall counter:
- stall_cnt increments on every cycle where stall && !branch_taken_EX && !rst.
- It saturates at 16'hFFFF.
- It clears on rst.

## Timing
- All control outputs are combinational from the inputs and the current state, and are valid in the same cycle. No output latency.
- State and counters update on the posedge of clk.
- Reset values:
  - state=IDLE, cnt=0, stall_cnt=0.
  - md_busy=0, md_done=0.
  - Control outputs as listed under rst priority.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and forwarding covers it.
- A mul/div accepted at edge k has md_busy=1 for cycles k+1 through k+N, where N is the selected cycle count. md_done=1 in cycle k+N only. State is IDLE from k+N+1.
- An mfhi or a second mult waiting in ID proceeds in cycle k+N+1.
- Reset asserted mid-operation drops to IDLE at the next edge. No md_done pulse is produced.
- With MUL_CYCLES=1, md_done is asserted in the first busy cycle.

## Structure
- Shared package hazard_pkg holds:
  - md_state_t (IDLE=2'd0, MUL=2'd1, DIV=2'd2).
  - REG_ZERO=5'd0.
  - Default MUL_CYCLES and DIV_CYCLES constants, shared with the HI/LO datapath.
- One sub-module, md_seq: the FSM, cnt, and generation of md_busy and md_done.
- The top-level holds the hazard terms, the priority mux and stall_cnt.

## Test plan
- **Load-use**: lw $t0 in EX with rs_id=8, uses_rs_id=1.
  - Required: one cycle of pc_wr=0, ifid_wr=0, idex_flush=1.
  - Required: normal outputs next cycle; stall_cnt=1.
- **Load to $zero**: lw with rw_EX=0 and rs_id=0.
  - Required: no stall; pc_wr=1, idex_flush=0.
- **Branch beats stall**: branch_taken_EX=1 together with load_use=1.
  - Required: pc_wr=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged.
- **Divide then mflo**: div accepted, md_read_ID=1 on the following instruction, DIV_CYCLES=32.
  - Required: md_busy=1 for 32 cycles, with md_done on the 32nd.
  - Required: 32 stall cycles, after which mflo advances.
- **Jump during load-use**: jump_ID=1 with load_use=1.
  - Required: stall first with no flush, then ifid_flush=1 on the next cycle.
- **Reset mid-multiply**: rst asserted at busy cycle 2 of 4.
  - Required: state IDLE, md_busy=0, no md_done, stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the HI/LO datapath.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MUL_CYCLES_DEF = 4;
  localparam int         DIV_CYCLES_DEF = 32;

  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RESET  = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_JUMP   = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
  localparam pipe_ctrl_t CTRL_RUN    = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};

  // True when an ID source operand is read and matches the EX destination.
  function automatic logic src_hit(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX hazard inputs and PC/IF/ID/ID/EX controls.
interface hazard_ctrl_if;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       uses_rs_id;
  logic       uses_rt_id;
  logic       MemRead_EX;
  logic [4:0] rw_EX;
  logic       branch_taken_EX;
  logic       jump_ID;
  logic       md_start_ID;
  logic       md_is_div_ID;
  logic       md_read_ID;
  logic       pc_wr;
  logic       ifid_wr;
  logic       ifid_flush;
  logic       idex_flush;
  logic       md_busy;
  logic       md_done;
  logic [15:0] stall_cnt;

  modport master (
    output rs_id, rt_id, uses_rs_id, uses_rt_id, MemRead_EX, rw_EX,
           branch_taken_EX, jump_ID, md_start_ID, md_is_div_ID, md_read_ID,
    input  pc_wr, ifid_wr, ifid_flush, idex_flush, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs_id, rt_id, uses_rs_id, uses_rt_id, MemRead_EX, rw_EX,
           branch_taken_EX, jump_ID, md_start_ID, md_is_div_ID, md_read_ID,
    output pc_wr, ifid_wr, ifid_flush, idex_flush, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Mul/div occupancy sequencer: tracks the EX-resident operation and flags its final (HI/LO write) cycle.
module md_seq
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_accept,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_first;

  assign w_first = i_is_div ? DIV_LAST : MUL_LAST;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_accept) begin
            r_state <= i_is_div ? DIV : MUL;
            r_cnt   <= w_first;
            r_busy  <= 1'b1;
            r_done  <= (w_first == '0);
          end
        end
        MUL, DIV: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use and mul/div stalls, branch/jump flushes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  logic       w_load_use;
  logic       w_md_busy;
  logic       w_md_done;
  logic       w_md_stall;
  logic       w_stall;
  logic       w_accept;
  pipe_ctrl_t w_ctrl;
  logic [15:0] r_stall_cnt;

  assign w_load_use = bus.MemRead_EX && (bus.rw_EX != REG_ZERO) &&
                      (src_hit(bus.uses_rs_id, bus.rs_id, bus.rw_EX) ||
                       src_hit(bus.uses_rt_id, bus.rt_id, bus.rw_EX));
  assign w_md_stall = w_md_busy && (bus.md_start_ID || bus.md_read_ID);
  assign w_stall    = w_load_use || w_md_stall;
  assign w_accept   = bus.md_start_ID && !w_stall && !bus.branch_taken_EX && !rst;

  md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_is_div (bus.md_is_div_ID),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done)
  );

  // NOTE: default assignment first so no path through the mux can infer a latch.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (rst)                      w_ctrl = CTRL_RESET;
    else if (bus.branch_taken_EX) w_ctrl = CTRL_BRANCH;  // squashed ID makes any stall moot
    else if (w_stall)             w_ctrl = CTRL_STALL;
    else if (bus.jump_ID)         w_ctrl = CTRL_JUMP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !bus.branch_taken_EX && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.pc_wr      = w_ctrl.pc_wr;
  assign bus.ifid_wr    = w_ctrl.ifid_wr;
  assign bus.ifid_flush = w_ctrl.ifid_flush;
  assign bus.idex_flush = w_ctrl.idex_flush;
  assign bus.md_busy    = w_md_busy;
  assign bus.md_done    = w_md_done;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven hazard vectors plus multi-cycle mul/div sequences.
module tb_hazard_ctrl;

  localparam logic [3:0] C_RST   = 4'b0011;
  localparam logic [3:0] C_BR    = 4'b1111;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_JMP   = 4'b1110;
  localparam logic [3:0] C_RUN   = 4'b1100;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mem;
    logic [4:0] rw;
    logic       br;
    logic       jmp;
    logic       mds;
    logic       mdiv;
    logic       mdr;
  } in_t;

  typedef struct packed {
    logic [3:0]  ctl;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [3:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if u_if ();
  hazard_ctrl_if u_if1 ();

  hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk (clk), .rst (rst), .bus (u_if.slave)
  );
  hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(2), .CNT_W(6)) dut1 (
    .clk (clk), .rst (rst), .bus (u_if1.slave)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] model_cnt = '0;
  exp_t        exp_q[$];
  string       name_q[$];
  vec_t        tbl[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic in_t f_lu(input logic [4:0] r);
    in_t v = '0;
    v.rs = r; v.urs = 1'b1; v.mem = 1'b1; v.rw = r;
    return v;
  endfunction

  function automatic in_t f_md(input logic start, input logic is_div, input logic rd);
    in_t v = '0;
    v.mds = start; v.mdiv = is_div; v.mdr = rd;
    return v;
  endfunction

  task automatic drive(input in_t v);
    rst                  = v.rst;
    u_if.rs_id           = v.rs;
    u_if.rt_id           = v.rt;
    u_if.uses_rs_id      = v.urs;
    u_if.uses_rt_id      = v.urt;
    u_if.MemRead_EX      = v.mem;
    u_if.rw_EX           = v.rw;
    u_if.branch_taken_EX = v.br;
    u_if.jump_ID         = v.jmp;
    u_if.md_start_ID     = v.mds;
    u_if.md_is_div_ID    = v.mdiv;
    u_if.md_read_ID      = v.mdr;
  endtask

  task automatic compare();
    exp_t  e  = exp_q.pop_front();
    string nm = name_q.pop_front();
    check({nm, ".ctl"}, 32'({u_if.pc_wr, u_if.ifid_wr, u_if.ifid_flush, u_if.idex_flush}), 32'(e.ctl));
    check({nm, ".md"},  32'({u_if.md_busy, u_if.md_done}), 32'({e.busy, e.done}));
    check({nm, ".cnt"}, 32'(u_if.stall_cnt), 32'(e.cnt));
  endtask

  // One clock: drive after the edge, queue the expectation, compare on the falling edge.
  task automatic cycle(input string nm, input in_t v, input logic [3:0] ctl,
                       input logic busy, input logic done);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.ctl = ctl; e.busy = busy; e.done = done; e.cnt = model_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    compare();
    if (v.rst) model_cnt = '0;
    else if (ctl == C_STALL && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
  endtask

  initial begin
    in_t v;
    u_if1.rs_id = '0; u_if1.rt_id = '0; u_if1.uses_rs_id = 1'b0; u_if1.uses_rt_id = 1'b0;
    u_if1.MemRead_EX = 1'b0; u_if1.rw_EX = '0; u_if1.branch_taken_EX = 1'b0;
    u_if1.jump_ID = 1'b0; u_if1.md_start_ID = 1'b0; u_if1.md_is_div_ID = 1'b0; u_if1.md_read_ID = 1'b0;
    v = '0; v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);

    v = '0; v.rst = 1'b1;              tbl[0]  = '{"reset", v, C_RST};
    v = '0;                            tbl[1]  = '{"idle", v, C_RUN};
    v = f_lu(5'd8);                    tbl[2]  = '{"lu_rs", v, C_STALL};
    v = '0;                            tbl[3]  = '{"lu_after", v, C_RUN};
    v = '0; v.rt = 5'd9; v.urt = 1'b1; v.mem = 1'b1; v.rw = 5'd9;
                                       tbl[4]  = '{"lu_rt", v, C_STALL};
    v.urt = 1'b0;                      tbl[5]  = '{"rt_unused", v, C_RUN};
    v = f_lu(5'd0);                    tbl[6]  = '{"lw_zero", v, C_RUN};
    v = f_lu(5'd8); v.mem = 1'b0;      tbl[7]  = '{"no_load", v, C_RUN};
    v = f_lu(5'd8); v.rw = 5'd7;       tbl[8]  = '{"reg_miss", v, C_RUN};
    v = f_lu(5'd8); v.br = 1'b1;       tbl[9]  = '{"br_beats_lu", v, C_BR};
    v = '0; v.br = 1'b1;               tbl[10] = '{"branch", v, C_BR};
    v = '0; v.jmp = 1'b1;              tbl[11] = '{"jump", v, C_JMP};
    v = f_lu(5'd12); v.jmp = 1'b1;     tbl[12] = '{"jump_lu", v, C_STALL};
    v = '0; v.jmp = 1'b1;              tbl[13] = '{"jump_retry", v, C_JMP};
    v = f_md(1'b0, 1'b0, 1'b1);        tbl[14] = '{"mfhi_idle", v, C_RUN};
    v = f_lu(5'd8); v.rst = 1'b1;      tbl[15] = '{"rst_over_lu", v, C_RST};

    for (int k = 0; k < 16; k++) cycle(tbl[k].name, tbl[k].i, tbl[k].ctl, 1'b0, 1'b0);

    // Divide followed by mflo: 32 busy/stall cycles, done on the last.
    cycle("div_acc", f_md(1'b1, 1'b1, 1'b0), C_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++)
      cycle("div_wait", f_md(1'b0, 1'b0, 1'b1), C_STALL, 1'b1, (i == 31));
    cycle("mflo_go", f_md(1'b0, 1'b0, 1'b1), C_RUN, 1'b0, 1'b0);

    // Multiply survives a taken branch; a second mult waits then issues.
    cycle("mul_acc", f_md(1'b1, 1'b0, 1'b0), C_RUN, 1'b0, 1'b0);
    v = f_md(1'b1, 1'b0, 1'b0); v.br = 1'b1;
    cycle("mul_br", v, C_BR, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++)
      cycle("mul2_wait", f_md(1'b1, 1'b0, 1'b0), C_STALL, 1'b1, (i == 4));
    cycle("mul2_acc", f_md(1'b1, 1'b0, 1'b0), C_RUN, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++)
      cycle("mul2_busy", '0, C_RUN, 1'b1, (i == 4));
    cycle("mul2_idle", '0, C_RUN, 1'b0, 1'b0);

    // Accept is blocked by a load-use stall and by a taken branch.
    v = f_lu(5'd8); v.mds = 1'b1;
    cycle("mds_lu", v, C_STALL, 1'b0, 1'b0);
    cycle("mds_lu_next", '0, C_RUN, 1'b0, 1'b0);
    v = f_md(1'b1, 1'b0, 1'b0); v.br = 1'b1;
    cycle("mds_br", v, C_BR, 1'b0, 1'b0);
    cycle("mds_br_next", '0, C_RUN, 1'b0, 1'b0);

    // Reset at busy cycle 2 of a multiply: no done pulse, counters cleared.
    cycle("rmul_acc", f_md(1'b1, 1'b0, 1'b0), C_RUN, 1'b0, 1'b0);
    cycle("rmul_b1", '0, C_RUN, 1'b1, 1'b0);
    v = '0; v.rst = 1'b1;
    cycle("rmul_rst", v, C_RST, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("rmul_after", '0, C_RUN, 1'b0, 1'b0);

    // Single-cycle multiply: done in the first busy cycle.
    @(posedge clk); #1;
    u_if1.md_start_ID = 1'b1;
    @(negedge clk);
    check("m1_acc.md", 32'({u_if1.md_busy, u_if1.md_done}), 32'(2'b00));
    @(posedge clk); #1;
    u_if1.md_start_ID = 1'b0;
    @(negedge clk);
    check("m1_busy.md", 32'({u_if1.md_busy, u_if1.md_done}), 32'(2'b11));
    @(posedge clk); #1;
    @(negedge clk);
    check("m1_idle.md", 32'({u_if1.md_busy, u_if1.md_done}), 32'(2'b00));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
